axi_bram_bridge: RTL and testbench
==================================

# axi_bram_bridge

- AXI4-Lite slave that turns processing-system register accesses into cycles on the pipelined processor's single shared BRAM port (`bram_din`, `shared_bram_addr`, `bram_wr_en`, `bram_dout`).
- Sits directly upstream of the processor top; the PS uses it to load instruction memory and to read and write the four data memories.
- Provides an optional control register that holds the core in reset while memory is loaded.

## Interface

**Parameters**
- `SIZE`, default 1024: words per memory. `LOGSIZE = $clog2(SIZE)`.
- `ADDR_W`, default LOGSIZE+4: AXI byte-address width.

**Ports**
- `clk`, in, 1: single clock.
- `reset`, in, 1: asynchronous, active-low reset.
- `s_awaddr`, in, ADDR_W. `s_awvalid`, in, 1. `s_awready`, out, 1.
- `s_wdata`, in, 32. `s_wstrb`, in, 4. `s_wvalid`, in, 1. `s_wready`, out, 1.
- `s_bresp`, out, 2. `s_bvalid`, out, 1. `s_bready`, in, 1.
- `s_araddr`, in, ADDR_W. `s_arvalid`, in, 1. `s_arready`, out, 1.
- `s_rdata`, out, 32. `s_rresp`, out, 2. `s_rvalid`, out, 1. `s_rready`, in, 1.
- `bram_din`, out, 32: write data to the processor.
- `shared_bram_addr`, out, LOGSIZE+3: byte address. Bit LOGSIZE+2 = 0 selects instruction memory, 1 selects data memory.
- `bram_wr_en`, out, 4: byte write enables.
- `bram_dout`, in, 32: read data. Valid one cycle after the address is presented.
- `core_hold`, out, 1: high holds the processor in reset.

## Operation

**Address decode**
- Address bit LOGSIZE+3 = 0 selects the BRAM region; bits LOGSIZE+2:2 pass to `shared_bram_addr`, with `shared_bram_addr[1:0]` forced to 0.
- Address bit LOGSIZE+3 = 1 selects the control region (see Configuration).

**FSM states:** IDLE, WR_ISSUE, WR_RESP, RD_ISSUE, RD_WAIT, RD_RESP.

**IDLE**
- `s_awready`, `s_wready` and `s_arready` are combinational grants, asserted only in IDLE.
- A write is eligible only when `s_awvalid` and `s_wvalid` are both high; AW and W are accepted in the same cycle.
- If a write and a read are both eligible, they are granted round-robin: the class not granted last wins. The first grant after reset goes to the write.
- A write grant registers address, data and strobes and moves to WR_ISSUE. A read grant registers the address and moves to RD_ISSUE.

**Write path**
- WR_ISSUE: drive `shared_bram_addr`, `bram_din` = wdata, `bram_wr_en` = wstrb for exactly one cycle, then go to WR_RESP.
- A control-region write updates the register instead; `bram_wr_en` stays 0.
- WR_RESP: `s_bvalid`=1, `s_bresp`=OKAY. Hold until `s_bready`, then return to IDLE.

**Read path**
- RD_ISSUE: drive the address with `bram_wr_en`=0, then go to RD_WAIT.
- RD_WAIT: capture `bram_dout` into `s_rdata`, or the control word for control-region reads, then go to RD_RESP.
- RD_RESP: `s_rvalid`=1, `s_rresp`=OKAY. `s_rdata` is stable until `s_rready`, then return to IDLE.

**Responses and corner cases**
- `s_bresp` and `s_rresp` are always OKAY (2'b00).
- `s_wstrb`=0 performs no write but still returns a response.
- Only one transaction is outstanding at a time.

## Timing

**Reset values (`reset` low)**
- Outputs: all ready/valid signals 0; `s_rdata`, `bram_din`, `shared_bram_addr`, `bram_wr_en` all 0; `core_hold`=1.
- State: FSM in IDLE; round-robin pointer set to "write next".

**Write latency**
- Handshake in cycle N.
- `bram_wr_en` is high during cycle N+1, so the BRAM commits at the end of N+1.
- `s_bvalid` rises in N+2.

**Read latency**
- Handshake in cycle N; address driven in N+1; `bram_dout` sampled at the end of N+2.
- `s_rvalid` rises in N+3.

**Address between accesses**
- `shared_bram_addr` holds its last value outside WR_ISSUE and RD_ISSUE.
- The processor registers its read-mux select from this address, so the address must stay stable through RD_WAIT.

**Reset mid-transaction**
- The in-flight access is dropped and no response is issued.
- A write already issued in WR_ISSUE may have committed.

## Configuration

- `AXI_BRIDGE_CTRL_REG_EN` defined:
  - The control region holds one register. Bit 0 is `core_hold`, reset value 1.
  - A control-region write with `s_wstrb[0]`=1 loads `s_wdata[0]`.
  - A control-region read returns `{31'b0, core_hold}`.
  - Control accesses never touch the BRAM port.
- `AXI_BRIDGE_CTRL_REG_EN` undefined:
  - Address bit LOGSIZE+3 is ignored, so both regions alias the BRAM.
  - `core_hold` is tied to 0 and no control register exists.

## Test plan

- **Instruction write.** Write 0x00500093 to 0x0004 with wstrb 0xF → `bram_wr_en`=0xF and `shared_bram_addr`=0x0004 for one cycle; `s_bvalid` two cycles after the handshake.
- **Data read.** Write 0xDEADBEEF to 0x1008 (SIZE=1024), then read 0x1008 → `s_rvalid` three cycles after the AR handshake, `s_rdata`=0xDEADBEEF, `s_rresp`=0.
- **Byte strobe and unaligned address.** Write to 0x100B with wstrb 0x2 → `shared_bram_addr`=0x1008, `bram_wr_en`=0x2.
- **Arbitration and backpressure.**
  - Assert a write and a read together twice in a row → write granted first, then read.
  - Hold `s_rready` low for 5 cycles → `s_rdata` stable throughout, `s_rvalid` held.
- **Control register (macro defined).**
  - After reset, `core_hold`=1.
  - Write 0x0 to 0x2000 → `core_hold`=0 and `bram_wr_en` never asserted.
  - Read 0x2000 → 0x0.
- **Reset mid-read.** Assert `reset` low in RD_WAIT → all outputs return to reset values, no `s_rvalid`; the next read completes normally.

Source files
------------

// File: rtl/axi_bram_bridge.sv
// AXI4-Lite slave that turns PS register accesses into cycles on the processor's shared BRAM port.
// Define AXI_BRIDGE_CTRL_REG_EN to map a core_hold control register into the upper address region.
module axi_bram_bridge #(
  parameter int SIZE   = 1024,
  parameter int ADDR_W = $clog2(SIZE) + 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [ADDR_W-1:0]         s_awaddr,
  input  logic                      s_awvalid,
  output logic                      s_awready,
  input  logic [31:0]               s_wdata,
  input  logic [3:0]                s_wstrb,
  input  logic                      s_wvalid,
  output logic                      s_wready,
  output logic [1:0]                s_bresp,
  output logic                      s_bvalid,
  input  logic                      s_bready,
  input  logic [ADDR_W-1:0]         s_araddr,
  input  logic                      s_arvalid,
  output logic                      s_arready,
  output logic [31:0]               s_rdata,
  output logic [1:0]                s_rresp,
  output logic                      s_rvalid,
  input  logic                      s_rready,
  output logic [31:0]               bram_din,
  output logic [$clog2(SIZE)+2:0]   shared_bram_addr,
  output logic [3:0]                bram_wr_en,
  input  logic [31:0]               bram_dout,
  output logic                      core_hold
);
  localparam int LOGSIZE = $clog2(SIZE);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] WR_ISSUE = 3'd1;
  localparam logic [2:0] WR_RESP  = 3'd2;
  localparam logic [2:0] RD_ISSUE = 3'd3;
  localparam logic [2:0] RD_WAIT  = 3'd4;
  localparam logic [2:0] RD_RESP  = 3'd5;

  logic [2:0]  state;
  logic        wr_next;
  logic        req_ctrl;
  logic        wr_go;
  logic        rd_go;
  logic        aw_ctrl;
  logic        ar_ctrl;
  logic [31:0] ctrl_word;
  logic        unused_addr;

  // Round-robin only matters when both classes are eligible in the same cycle.
  assign wr_go = (state == IDLE) && s_awvalid && s_wvalid && (wr_next || !s_arvalid);
  assign rd_go = (state == IDLE) && s_arvalid && !wr_go;

  assign s_awready = wr_go;
  assign s_wready  = wr_go;
  assign s_arready = rd_go;
  assign s_bresp   = 2'b00;
  assign s_rresp   = 2'b00;

  assign unused_addr = ^{s_awaddr, s_araddr};

`ifdef AXI_BRIDGE_CTRL_REG_EN
  assign aw_ctrl = s_awaddr[LOGSIZE+3];
  assign ar_ctrl = s_araddr[LOGSIZE+3];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      core_hold <= 1'b1;
    end else if (wr_go && aw_ctrl && s_wstrb[0]) begin
      core_hold <= s_wdata[0];
    end
  end
`else
  assign aw_ctrl   = 1'b0;
  assign ar_ctrl   = 1'b0;
  assign core_hold = 1'b0;
`endif

  assign ctrl_word = {31'b0, core_hold};

  // BRAM-side outputs are registered at the grant edge so the issue cycle drives them cleanly;
  // the address is left alone otherwise because the core registers its read mux from it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      wr_next          <= 1'b1;
      req_ctrl         <= 1'b0;
      s_bvalid         <= 1'b0;
      s_rvalid         <= 1'b0;
      s_rdata          <= '0;
      bram_din         <= '0;
      shared_bram_addr <= '0;
      bram_wr_en       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (wr_go) begin
            wr_next  <= 1'b0;
            req_ctrl <= aw_ctrl;
            state    <= WR_ISSUE;
            if (!aw_ctrl) begin
              shared_bram_addr <= {s_awaddr[LOGSIZE+2:2], 2'b00};
              bram_din         <= s_wdata;
              bram_wr_en       <= s_wstrb;
            end
          end else if (rd_go) begin
            wr_next  <= 1'b1;
            req_ctrl <= ar_ctrl;
            state    <= RD_ISSUE;
            if (!ar_ctrl) begin
              shared_bram_addr <= {s_araddr[LOGSIZE+2:2], 2'b00};
            end
          end
        end
        WR_ISSUE: begin
          bram_wr_en <= '0;
          s_bvalid   <= 1'b1;
          state      <= WR_RESP;
        end
        WR_RESP: begin
          if (s_bready) begin
            s_bvalid <= 1'b0;
            state    <= IDLE;
          end
        end
        RD_ISSUE: begin
          state <= RD_WAIT;
        end
        RD_WAIT: begin
          s_rdata  <= req_ctrl ? ctrl_word : bram_dout;
          s_rvalid <= 1'b1;
          state    <= RD_RESP;
        end
        RD_RESP: begin
          if (s_rready) begin
            s_rvalid <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_bram_bridge.sv
// Scoreboarded randomized bench for axi_bram_bridge with a behavioural memory/arbitration model.
module tb_axi_bram_bridge;
  localparam int SIZE    = 1024;
  localparam int LOGSIZE = 10;
  localparam int ADDR_W  = 14;
`ifdef AXI_BRIDGE_CTRL_REG_EN
  localparam logic HOLD_RST = 1'b1;
`else
  localparam logic HOLD_RST = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] s_awaddr, s_araddr;
  logic              s_awvalid, s_awready, s_wvalid, s_wready;
  logic [31:0]       s_wdata, s_rdata;
  logic [3:0]        s_wstrb;
  logic [1:0]        s_bresp, s_rresp;
  logic              s_bvalid, s_bready, s_arvalid, s_arready, s_rvalid, s_rready;
  logic [31:0]       bram_din, bram_dout;
  logic [LOGSIZE+2:0] shared_bram_addr;
  logic [3:0]        bram_wr_en;
  logic              core_hold;

  axi_bram_bridge #(.SIZE(SIZE), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .bram_din(bram_din), .shared_bram_addr(shared_bram_addr), .bram_wr_en(bram_wr_en),
    .bram_dout(bram_dout), .core_hold(core_hold)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Processor-side BRAM: one-cycle read latency, byte write enables.
  logic [31:0] bram [0:2*SIZE-1];
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (bram_wr_en[i]) bram[shared_bram_addr[LOGSIZE+2:2]][8*i +: 8] <= bram_din[8*i +: 8];
    bram_dout <= bram[shared_bram_addr[LOGSIZE+2:2]];
  end

  typedef struct packed { logic is_wr; logic [LOGSIZE+2:0] addr; logic chk; } grant_t;
  typedef struct packed { logic [LOGSIZE+2:0] addr; logic [31:0] data; logic [3:0] strb; } bwr_t;

  grant_t      exp_grant[$];
  bwr_t        exp_bram[$];
  logic [31:0] exp_r[$];
  logic [31:0] ref_mem [int];
  logic        model_hold = HOLD_RST;
  logic        rr_wr_next = 1'b1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    errors++;
    $display("FAIL %s: unexpected event (cycle %0d)", name, cyc);
  endtask

  function automatic logic is_ctrl(input logic [ADDR_W-1:0] a);
`ifdef AXI_BRIDGE_CTRL_REG_EN
    return a[LOGSIZE+3];
`else
    return 1'b0;
`endif
  endfunction

  function automatic int widx(input logic [ADDR_W-1:0] a);
    return int'(a[LOGSIZE+2:2]);
  endfunction

  task automatic model_w(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic [3:0] s);
    grant_t g;
    bwr_t bw;
    logic [31:0] w;
    g.is_wr = 1'b1; g.addr = {a[LOGSIZE+2:2], 2'b00}; g.chk = 1'b0;
    exp_grant.push_back(g);
    rr_wr_next = 1'b0;
    if (is_ctrl(a)) begin
      if (s[0]) model_hold = d[0];
    end else begin
      if (s != 4'h0) begin
        bw.addr = g.addr; bw.data = d; bw.strb = s;
        exp_bram.push_back(bw);
      end
      w = ref_mem.exists(widx(a)) ? ref_mem[widx(a)] : 32'h0;
      for (int i = 0; i < 4; i++) if (s[i]) w[8*i +: 8] = d[8*i +: 8];
      ref_mem[widx(a)] = w;
    end
  endtask

  task automatic model_r(input logic [ADDR_W-1:0] a);
    grant_t g;
    g.is_wr = 1'b0; g.addr = {a[LOGSIZE+2:2], 2'b00}; g.chk = !is_ctrl(a);
    exp_grant.push_back(g);
    rr_wr_next = 1'b1;
    if (is_ctrl(a)) exp_r.push_back({31'b0, model_hold});
    else exp_r.push_back(ref_mem.exists(widx(a)) ? ref_mem[widx(a)] : 32'h0);
  endtask

  // Issues an optional write and/or read together and runs until both responses are accepted.
  task automatic txn(input bit dw, input logic [ADDR_W-1:0] wa, input logic [31:0] wd,
                     input logic [3:0] ws, input bit dr, input logic [ADDR_W-1:0] ra, input int stall);
    bit w_done, r_done, aw_f, ar_f, b_f, r_f;
    int n, st;
    if (!dr || (dw && rr_wr_next)) begin
      if (dw) model_w(wa, wd, ws);
      if (dr) model_r(ra);
    end else begin
      model_r(ra);
      if (dw) model_w(wa, wd, ws);
    end
    s_awaddr = wa; s_wdata = wd; s_wstrb = ws; s_araddr = ra;
    s_awvalid = dw; s_wvalid = dw; s_arvalid = dr;
    st = stall;
    s_rready = (st == 0);
    w_done = !dw; r_done = !dr; n = 0;
    while (!(w_done && r_done) && n < 100) begin
      @(negedge clk);
      aw_f = s_awvalid && s_awready; ar_f = s_arvalid && s_arready;
      b_f = s_bvalid && s_bready;    r_f = s_rvalid && s_rready;
      @(posedge clk); #1;
      n++;
      if (aw_f) begin s_awvalid = 1'b0; s_wvalid = 1'b0; end
      if (ar_f) s_arvalid = 1'b0;
      if (b_f) w_done = 1'b1;
      if (r_f) r_done = 1'b1;
      if (s_rvalid && st > 0) st--;
      s_rready = (st == 0);
    end
    if (n >= 100) begin
      flag("txn_timeout");
      s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
    end
    s_rready = 1'b1;
    check("core_hold", core_hold, model_hold);
  endtask

  task automatic check_reset_outputs();
    check("rst_awready", s_awready, 0); check("rst_wready", s_wready, 0);
    check("rst_arready", s_arready, 0); check("rst_bvalid", s_bvalid, 0);
    check("rst_rvalid", s_rvalid, 0);   check("rst_rdata", s_rdata, 0);
    check("rst_bram_din", bram_din, 0); check("rst_bram_addr", shared_bram_addr, 0);
    check("rst_wr_en", bram_wr_en, 0);  check("rst_core_hold", core_hold, HOLD_RST);
  endtask

  // Monitor: pops scoreboard entries whenever the DUT grants or presents output.
  int wr_hs = -100, ar_hs = -100;
  logic [LOGSIZE+2:0] rd_addr;
  logic rd_chk = 1'b0, bvalid_d = 1'b0, rvalid_d = 1'b0, rready_d = 1'b1;
  logic [31:0] rdata_hold;
  initial begin
    grant_t g;
    bwr_t bw;
    logic [31:0] er;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (s_awready && s_arready) flag("dual_grant");
        if ((s_awvalid && s_awready) || (s_arvalid && s_arready)) begin
          if (exp_grant.size() == 0) flag("unexpected_grant");
          else begin
            g = exp_grant.pop_front();
            check("grant_class", s_awready, g.is_wr);
            if (s_awready) begin
              check("w_with_aw", s_wvalid && s_wready, 1);
              wr_hs = cyc;
            end else begin
              ar_hs = cyc; rd_addr = g.addr; rd_chk = g.chk;
            end
          end
        end
        if (rd_chk && (cyc == ar_hs + 1 || cyc == ar_hs + 2))
          check("rd_addr_stable", shared_bram_addr, rd_addr);
        if (bram_wr_en != 4'h0) begin
          if (exp_bram.size() == 0) flag("unexpected_bram_write");
          else begin
            bw = exp_bram.pop_front();
            check("bram_wr_addr", shared_bram_addr, bw.addr);
            check("bram_wr_data", bram_din, bw.data);
            check("bram_wr_en", bram_wr_en, bw.strb);
            check("bram_wr_latency", cyc - wr_hs, 1);
          end
        end
        if (s_bvalid && !bvalid_d) begin
          check("b_latency", cyc - wr_hs, 2);
          check("bresp", s_bresp, 0);
        end
        if (rvalid_d && !rready_d) check("rvalid_held", s_rvalid, 1);
        if (s_rvalid && !rvalid_d) begin
          check("r_latency", cyc - ar_hs, 3);
          rdata_hold = s_rdata;
        end else if (s_rvalid) begin
          check("rdata_stable", s_rdata, rdata_hold);
        end
        if (s_rvalid && s_rready) begin
          check("rresp", s_rresp, 0);
          if (exp_r.size() == 0) flag("unexpected_rdata");
          else begin
            er = exp_r.pop_front();
            check("rdata", s_rdata, er);
          end
        end
      end
      bvalid_d = s_bvalid && reset;
      rvalid_d = s_rvalid && reset;
      rready_d = s_rready;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [ADDR_W-1:0] pool [8];
  initial begin
    logic [ADDR_W-1:0] wa, ra;
    int op;
    pool[0] = 14'h0004; pool[1] = 14'h1008; pool[2] = 14'h0010; pool[3] = 14'h1010;
    pool[4] = 14'h0ffc; pool[5] = 14'h1ffc; pool[6] = 14'h0000; pool[7] = 14'h1000;
    reset = 1'b0;
    s_awaddr = '0; s_awvalid = 1'b0; s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0;
    s_bready = 1'b1; s_araddr = '0; s_arvalid = 1'b0; s_rready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    reset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) txn(1, pool[i], $urandom, 4'hF, 0, '0, 0);
    txn(1, 14'h0004, 32'h00500093, 4'hF, 0, '0, 0);
    txn(1, 14'h1008, 32'hDEADBEEF, 4'hF, 0, '0, 0);
    txn(0, '0, '0, '0, 1, 14'h1008, 0);
    txn(1, 14'h100B, 32'h0000A500, 4'h2, 0, '0, 0);
    txn(0, '0, '0, '0, 1, 14'h1008, 0);
    txn(1, 14'h0010, 32'h12345678, 4'h0, 1, 14'h0010, 0);
    txn(1, 14'h1010, 32'hCAFEF00D, 4'hF, 1, 14'h1010, 0);
    txn(1, 14'h1010, 32'h0BADC0DE, 4'hF, 1, 14'h1010, 0);
    txn(1, 14'h0ffc, 32'h55AA55AA, 4'hF, 0, '0, 0);
    txn(1, 14'h0ffc, 32'h11111111, 4'hF, 1, 14'h0ffc, 0);
    txn(0, '0, '0, '0, 1, 14'h0004, 5);
    txn(1, 14'h2000, 32'h0, 4'hF, 0, '0, 0);
    txn(0, '0, '0, '0, 1, 14'h2000, 0);

    for (int i = 0; i < 80; i++) begin
      op = $urandom_range(0, 2);
      wa = pool[$urandom_range(0, 7)] | ADDR_W'($urandom_range(0, 3));
      ra = pool[$urandom_range(0, 7)] | ADDR_W'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) wa[LOGSIZE+3] = 1'b1;
      if ($urandom_range(0, 3) == 0) ra[LOGSIZE+3] = 1'b1;
      txn(op != 1, wa, $urandom, 4'($urandom_range(0, 15)), op != 0, ra, $urandom_range(0, 3));
    end

    // Reset while the read sits in RD_WAIT: no response may appear.
    begin
      grant_t g;
      int n;
      bit f;
      g.is_wr = 1'b0; g.addr = 13'h1008; g.chk = 1'b1;
      exp_grant.push_back(g);
      s_araddr = 14'h1008; s_arvalid = 1'b1;
      n = 0; f = 1'b0;
      while (!f && n < 20) begin
        @(negedge clk);
        f = s_arvalid && s_arready;
        @(posedge clk); #1;
        n++;
      end
      if (!f) flag("rst_read_grant_timeout");
      s_arvalid = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      #1;
      check_reset_outputs();
      for (int i = 0; i < 3; i++) begin
        @(posedge clk); #1;
        check("rst_no_rvalid", s_rvalid, 0);
      end
      reset = 1'b1;
      rr_wr_next = 1'b1;
      model_hold = HOLD_RST;
      @(posedge clk); #1;
    end
    txn(0, '0, '0, '0, 1, 14'h1008, 0);
    txn(1, 14'h0010, 32'hA5A5A5A5, 4'hF, 1, 14'h0010, 1);

    repeat (5) @(posedge clk);
    #1;
    check("grant_q_empty", exp_grant.size(), 0);
    check("bram_q_empty", exp_bram.size(), 0);
    check("rdata_q_empty", exp_r.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
